// File: rtl/coin_acceptor_pkg.sv
// Shared coin codes and FSM state encoding for the coin acceptor.
package coin_acceptor_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_TWO  = 2'b11;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    EMIT,
    REJECT,
    RELEASE
  } state_t;

  function automatic logic [1:0] coin_code(input logic two);
    return two ? COIN_TWO : COIN_ONE;
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchronizer for one raw, asynchronous coin sensor.
module coin_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Debounced two-sensor coin acceptor with registered coin/reject outputs.
// Define COIN_ACCEPTOR_COUNT_EN to add a saturating accepted-coin counter (coin_count).
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_one,
  input  logic             sense_two,
  output logic [1:0]       coin,
  output logic             coin_reject,
`ifdef COIN_ACCEPTOR_COUNT_EN
  output logic [CNT_W-1:0] coin_count,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sense_raw;
  logic [1:0]       sense_sync;
  logic             s_one;
  logic             s_two;
  logic             latched;
  logic             other;
  logic             kind_two;
  logic [CNT_W-1:0] counter;
  state_t           state;

  assign sense_raw = {sense_two, sense_one};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    coin_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .raw  (sense_raw[gi]),
      .sync (sense_sync[gi])
    );
  end

  assign s_one   = sense_sync[0];
  assign s_two   = sense_sync[1];
  assign latched = kind_two ? s_two : s_one;
  assign other   = kind_two ? s_one : s_two;
  assign busy    = (state != IDLE);

  // coin/coin_reject are loaded on the transition so they line up with EMIT/REJECT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      counter     <= '0;
      kind_two    <= 1'b0;
      coin        <= COIN_NONE;
      coin_reject <= 1'b0;
    end else begin
      coin        <= COIN_NONE;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (s_one && s_two) begin
            state       <= REJECT;
            coin_reject <= 1'b1;
            counter     <= '0;
          end else if (s_one ^ s_two) begin
            state    <= QUAL;
            kind_two <= s_two;
            counter  <= CNT_W'(1);
          end
        end
        QUAL: begin
          if (other) begin
            state       <= REJECT;
            coin_reject <= 1'b1;
            counter     <= '0;
          end else if (!latched) begin
            state   <= IDLE;
            counter <= '0;
          end else if (counter == DEB) begin
            state   <= EMIT;
            coin    <= coin_code(kind_two);
            counter <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        EMIT, REJECT: begin
          state   <= RELEASE;
          counter <= '0;
        end
        RELEASE: begin
          // Only a run of DEBOUNCE_CYCLES all-clear cycles re-arms the acceptor.
          if (s_one || s_two) begin
            counter <= '0;
          end else if (counter + CNT_W'(1) == DEB) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

`ifdef COIN_ACCEPTOR_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_count <= '0;
    end else if (state == EMIT && coin_count != '1) begin
      coin_count <= coin_count + CNT_W'(1);
    end
  end
`endif

endmodule
